// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between instruction fetch and data memory
//
// Shares one variable-latency memory between the IF stage and the DM stage.
// DM is granted first because it holds the older instruction. IF is forced a
// grant after losing STARVE_MAX consecutive decisions. An access with no
// mem_ready within TIMEOUT cycles is aborted and flagged on mem_err.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   if_req, if_addr              fetch request and PC
//   if_rdata, if_valid           fetched word, one-cycle completion pulse
//   dm_memread, dm_mem_write     load / store request from the MEM stage
//   mem_address, dm_data_input   load/store address and store data
//   dm_rdata, dm_done            load data, one-cycle completion pulse
//   mem_req, mem_we, mem_addr,
//   mem_wdata                    registered memory request
//   mem_rdata, mem_ready         memory response
//   stall_if, stall_mem          pipeline freeze signals
//   mem_err                      sticky timeout flag
module mem_port_arbiter #(
    parameter int ad_size    = 32,
    parameter int d_size     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req,
    input  logic [ad_size-1:0] if_addr,
    output logic [d_size-1:0]  if_rdata,
    output logic               if_valid,
    input  logic               dm_memread,
    input  logic               dm_mem_write,
    input  logic [ad_size-1:0] mem_address,
    input  logic [d_size-1:0]  dm_data_input,
    output logic [d_size-1:0]  dm_rdata,
    output logic               dm_done,
    output logic               mem_req,
    output logic               mem_we,
    output logic [ad_size-1:0] mem_addr,
    output logic [d_size-1:0]  mem_wdata,
    input  logic [d_size-1:0]  mem_rdata,
    input  logic               mem_ready,
    output logic               stall_if,
    output logic               stall_mem,
    output logic               mem_err
);

    typedef enum logic [1:0] {IDLE, DATA, INST} state_t;

    state_t             state, state_nxt;
    logic [3:0]         starve_cnt, starve_nxt;
    logic [7:0]         tmo_cnt, tmo_nxt;
    logic               mem_req_nxt, mem_we_nxt, mem_err_nxt;
    logic [ad_size-1:0] mem_addr_nxt;
    logic [d_size-1:0]  mem_wdata_nxt, if_rdata_nxt, dm_rdata_nxt;
    logic               if_valid_nxt, dm_done_nxt;
    logic               dm_req;

    assign dm_req    = dm_memread | dm_mem_write;
    assign stall_mem = dm_req & ~dm_done;
    assign stall_if  = (if_req & ~if_valid) | stall_mem;

    always_comb begin
        state_nxt     = state;
        starve_nxt    = starve_cnt;
        tmo_nxt       = tmo_cnt;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        mem_err_nxt   = mem_err;
        if_rdata_nxt  = if_rdata;
        dm_rdata_nxt  = dm_rdata;
        if_valid_nxt  = 1'b0;
        dm_done_nxt   = 1'b0;

        case (state)
            IDLE: begin
                tmo_nxt = 8'd0;
                if (dm_req && (starve_cnt < 4'(STARVE_MAX))) begin
                    state_nxt     = DATA;
                    mem_req_nxt   = 1'b1;
                    // A simultaneous read+write request is treated as a write.
                    mem_we_nxt    = dm_mem_write;
                    mem_addr_nxt  = mem_address;
                    mem_wdata_nxt = dm_data_input;
                    if (if_req) begin
                        starve_nxt = starve_cnt + 4'd1;
                    end
                end else if (if_req) begin
                    state_nxt    = INST;
                    mem_req_nxt  = 1'b1;
                    mem_we_nxt   = 1'b0;
                    mem_addr_nxt = if_addr;
                    starve_nxt   = 4'd0;
                end
            end
            DATA, INST: begin
                // mem_ready on the last allowed cycle still completes normally.
                if (mem_ready || (tmo_cnt == 8'(TIMEOUT - 1))) begin
                    state_nxt   = IDLE;
                    mem_req_nxt = 1'b0;
                    if (!mem_ready) begin
                        mem_err_nxt = 1'b1;
                    end
                    if (state == DATA) begin
                        dm_done_nxt  = 1'b1;
                        dm_rdata_nxt = (mem_ready && !mem_we) ? mem_rdata : '0;
                    end else begin
                        if_valid_nxt = 1'b1;
                        if_rdata_nxt = mem_ready ? mem_rdata : '0;
                    end
                end else begin
                    tmo_nxt = tmo_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt   = IDLE;
                mem_req_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
            tmo_cnt    <= 8'd0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_err    <= 1'b0;
            if_rdata   <= '0;
            if_valid   <= 1'b0;
            dm_rdata   <= '0;
            dm_done    <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            tmo_cnt    <= tmo_nxt;
            mem_req    <= mem_req_nxt;
            mem_we     <= mem_we_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            mem_err    <= mem_err_nxt;
            if_rdata   <= if_rdata_nxt;
            if_valid   <= if_valid_nxt;
            dm_rdata   <= dm_rdata_nxt;
            dm_done    <= dm_done_nxt;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        dm_memread;
    logic        dm_mem_write;
    logic [31:0] mem_address;
    logic [31:0] dm_data_input;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall_if;
    logic        stall_mem;
    logic        mem_err;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ad_size(32), .d_size(32), .STARVE_MAX(4), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_memread(dm_memread), .dm_mem_write(dm_mem_write), .mem_address(mem_address),
        .dm_data_input(dm_data_input), .dm_rdata(dm_rdata), .dm_done(dm_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall_if(stall_if), .stall_mem(stall_mem), .mem_err(mem_err)
    );

    task automatic test_reset();
        rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_memread = 1'b0; dm_mem_write = 1'b0;
        mem_address = '0; dm_data_input = '0; mem_rdata = '0; mem_ready = 1'b0;
        @(negedge clk);
        tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL rst_mem_req: got %0b want 0", mem_req); end
        tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL rst_mem_we: got %0b want 0", mem_we); end
        tests_run++; if (mem_addr !== 32'h0) begin tests_failed++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
        tests_run++; if (mem_wdata !== 32'h0) begin tests_failed++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
        tests_run++; if (dm_done !== 1'b0 || if_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_pulses: got %0b%0b want 00", dm_done, if_valid); end
        tests_run++; if (dm_rdata !== 32'h0 || if_rdata !== 32'h0) begin tests_failed++; $display("FAIL rst_rdata: got %h %h want 0 0", dm_rdata, if_rdata); end
        tests_run++; if (mem_err !== 1'b0) begin tests_failed++; $display("FAIL rst_mem_err: got %0b want 0", mem_err); end
        tests_run++; if (stall_if !== 1'b0 || stall_mem !== 1'b0) begin tests_failed++; $display("FAIL rst_stall: got %0b%0b want 00", stall_if, stall_mem); end
        rst = 1'b0;
    endtask

    task automatic test_load();
        @(negedge clk);
        dm_memread = 1'b1; mem_address = 32'h40;
        #1;
        tests_run++; if (stall_mem !== 1'b1 || stall_if !== 1'b1) begin tests_failed++; $display("FAIL load_stall_req: got %0b%0b want 11", stall_if, stall_mem); end
        @(negedge clk);
        tests_run++; if (mem_req !== 1'b1) begin tests_failed++; $display("FAIL load_mem_req: got %0b want 1", mem_req); end
        tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL load_mem_we: got %0b want 0", mem_we); end
        tests_run++; if (mem_addr !== 32'h40) begin tests_failed++; $display("FAIL load_mem_addr: got %h want 40", mem_addr); end
        @(negedge clk);
        tests_run++; if (mem_req !== 1'b1 || stall_mem !== 1'b1) begin tests_failed++; $display("FAIL load_hold: got req=%0b stall=%0b want 1 1", mem_req, stall_mem); end
        @(negedge clk);
        tests_run++; if (mem_req !== 1'b1 || dm_done !== 1'b0) begin tests_failed++; $display("FAIL load_wait: got req=%0b done=%0b want 1 0", mem_req, dm_done); end
        mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        mem_ready = 1'b0;
        tests_run++; if (dm_done !== 1'b1) begin tests_failed++; $display("FAIL load_done: got %0b want 1", dm_done); end
        tests_run++; if (dm_rdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL load_rdata: got %h want deadbeef", dm_rdata); end
        tests_run++; if (mem_req !== 1'b0 || stall_mem !== 1'b0) begin tests_failed++; $display("FAIL load_release: got req=%0b stall=%0b want 0 0", mem_req, stall_mem); end
        dm_memread = 1'b0;
        @(negedge clk);
        tests_run++; if (dm_done !== 1'b0 || mem_req !== 1'b0) begin tests_failed++; $display("FAIL load_single_pulse: got done=%0b req=%0b want 0 0", dm_done, mem_req); end
        tests_run++; if (dm_rdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL load_rdata_hold: got %h want deadbeef", dm_rdata); end
    endtask

    task automatic test_store();
        dm_mem_write = 1'b1; mem_address = 32'h80; dm_data_input = 32'h12345678;
        @(negedge clk);
        tests_run++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin tests_failed++; $display("FAIL store_req: got req=%0b we=%0b want 1 1", mem_req, mem_we); end
        tests_run++; if (mem_wdata !== 32'h12345678 || mem_addr !== 32'h80) begin tests_failed++; $display("FAIL store_bus: got %h@%h want 12345678@80", mem_wdata, mem_addr); end
        @(negedge clk);
        mem_ready = 1'b1; mem_rdata = 32'hFFFF0000;
        @(negedge clk);
        mem_ready = 1'b0;
        tests_run++; if (dm_done !== 1'b1 || dm_rdata !== 32'h0) begin tests_failed++; $display("FAIL store_done: got done=%0b rdata=%h want 1 0", dm_done, dm_rdata); end
        dm_mem_write = 1'b0;
        @(negedge clk);
        tests_run++; if (dm_done !== 1'b0 || mem_req !== 1'b0) begin tests_failed++; $display("FAIL store_single_pulse: got done=%0b req=%0b want 0 0", dm_done, mem_req); end
    endtask

    task automatic test_priority();
        if_req = 1'b1; if_addr = 32'h100; dm_memread = 1'b1; mem_address = 32'h44;
        @(negedge clk);
        tests_run++; if (mem_req !== 1'b1 || mem_addr !== 32'h44) begin tests_failed++; $display("FAIL prio_data_first: got req=%0b addr=%h want 1 44", mem_req, mem_addr); end
        mem_ready = 1'b1; mem_rdata = 32'hAAAA0001;
        @(negedge clk);
        mem_ready = 1'b0;
        tests_run++; if (dm_done !== 1'b1 || if_valid !== 1'b0 || mem_req !== 1'b0) begin tests_failed++; $display("FAIL prio_gap: got done=%0b valid=%0b req=%0b want 1 0 0", dm_done, if_valid, mem_req); end
        tests_run++; if (stall_if !== 1'b1 || stall_mem !== 1'b0) begin tests_failed++; $display("FAIL prio_stalls: got if=%0b mem=%0b want 1 0", stall_if, stall_mem); end
        dm_memread = 1'b0;
        @(negedge clk);
        tests_run++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin tests_failed++; $display("FAIL prio_inst_grant: got req=%0b addr=%h we=%0b want 1 100 0", mem_req, mem_addr, mem_we); end
        mem_ready = 1'b1; mem_rdata = 32'h00000013;
        @(negedge clk);
        mem_ready = 1'b0;
        tests_run++; if (if_valid !== 1'b1 || if_rdata !== 32'h13 || stall_if !== 1'b0) begin tests_failed++; $display("FAIL prio_inst_done: got valid=%0b rdata=%h stall=%0b want 1 13 0", if_valid, if_rdata, stall_if); end
        if_req = 1'b0;
        @(negedge clk);
        tests_run++; if (if_valid !== 1'b0 || mem_req !== 1'b0) begin tests_failed++; $display("FAIL prio_idle: got valid=%0b req=%0b want 0 0", if_valid, mem_req); end
    endtask

    task automatic test_starvation();
        logic [31:0] exp_addr;
        dm_memread = 1'b1; mem_address = 32'h200; if_req = 1'b1; if_addr = 32'h300;
        for (int r = 0; r < 2; r++) begin
            for (int g = 0; g < 5; g++) begin
                exp_addr = (g < 4) ? 32'h200 : 32'h300;
                @(negedge clk);
                tests_run++; if (mem_req !== 1'b1 || mem_addr !== exp_addr) begin tests_failed++; $display("FAIL starve_grant r%0d g%0d: got req=%0b addr=%h want 1 %h", r, g, mem_req, mem_addr, exp_addr); end
                mem_ready = 1'b1; mem_rdata = 32'hCAFE0000 | 32'(g);
                @(negedge clk);
                mem_ready = 1'b0;
                if (g < 4) begin
                    tests_run++; if (dm_done !== 1'b1 || dm_rdata !== (32'hCAFE0000 | 32'(g))) begin tests_failed++; $display("FAIL starve_dm_done r%0d g%0d: got done=%0b rdata=%h", r, g, dm_done, dm_rdata); end
                end else begin
                    tests_run++; if (if_valid !== 1'b1 || if_rdata !== 32'hCAFE0004) begin tests_failed++; $display("FAIL starve_if_valid r%0d: got valid=%0b rdata=%h want 1 cafe0004", r, if_valid, if_rdata); end
                end
            end
        end
        dm_memread = 1'b0; if_req = 1'b0;
        @(negedge clk);
        tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL starve_idle: got req=%0b want 0", mem_req); end
    endtask

    task automatic test_timeout();
        dm_memread = 1'b1; mem_address = 32'h500;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            tests_run++; if (mem_req !== 1'b1 || mem_err !== 1'b0 || dm_done !== 1'b0) begin tests_failed++; $display("FAIL tmo_wait c%0d: got req=%0b err=%0b done=%0b want 1 0 0", i, mem_req, mem_err, dm_done); end
        end
        @(negedge clk);
        tests_run++; if (mem_req !== 1'b0 || mem_err !== 1'b1) begin tests_failed++; $display("FAIL tmo_abort: got req=%0b err=%0b want 0 1", mem_req, mem_err); end
        tests_run++; if (dm_done !== 1'b1 || dm_rdata !== 32'h0) begin tests_failed++; $display("FAIL tmo_done: got done=%0b rdata=%h want 1 0", dm_done, dm_rdata); end
        dm_memread = 1'b0;
        @(negedge clk);
        tests_run++; if (mem_err !== 1'b1 || dm_done !== 1'b0) begin tests_failed++; $display("FAIL tmo_sticky: got err=%0b done=%0b want 1 0", mem_err, dm_done); end
        dm_memread = 1'b1; mem_address = 32'h540;
        repeat (7) @(negedge clk);
        @(negedge clk);
        tests_run++; if (mem_req !== 1'b1) begin tests_failed++; $display("FAIL tmo_limit_req: got %0b want 1", mem_req); end
        mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
        @(negedge clk);
        mem_ready = 1'b0;
        tests_run++; if (dm_done !== 1'b1 || dm_rdata !== 32'h0BADF00D) begin tests_failed++; $display("FAIL tmo_ready_wins: got done=%0b rdata=%h want 1 0badf00d", dm_done, dm_rdata); end
        dm_memread = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        dm_memread = 1'b1; mem_address = 32'h600;
        @(negedge clk);
        tests_run++; if (mem_req !== 1'b1) begin tests_failed++; $display("FAIL rmid_req: got %0b want 1", mem_req); end
        rst = 1'b1;
        #1;
        tests_run++; if (mem_req !== 1'b0 || mem_err !== 1'b0 || dm_done !== 1'b0) begin tests_failed++; $display("FAIL rmid_async: got req=%0b err=%0b done=%0b want 0 0 0", mem_req, mem_err, dm_done); end
        dm_memread = 1'b0;
        @(negedge clk);
        tests_run++; if (dm_done !== 1'b0 || mem_req !== 1'b0) begin tests_failed++; $display("FAIL rmid_no_pulse: got done=%0b req=%0b want 0 0", dm_done, mem_req); end
        rst = 1'b0;
        @(negedge clk);
        dm_mem_write = 1'b1; mem_address = 32'h700; dm_data_input = 32'h55;
        @(negedge clk);
        tests_run++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h700 || mem_wdata !== 32'h55) begin tests_failed++; $display("FAIL rmid_new_req: got req=%0b we=%0b %h@%h want 1 1 55@700", mem_req, mem_we, mem_wdata, mem_addr); end
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        tests_run++; if (dm_done !== 1'b1 || mem_err !== 1'b0) begin tests_failed++; $display("FAIL rmid_new_done: got done=%0b err=%0b want 1 0", dm_done, mem_err); end
        dm_mem_write = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_priority();
        test_starvation();
        test_timeout();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
